// File: rtl/udp_cmd_frame_packer.sv
// udp_cmd_frame_packer
// Queues 40-bit {addr, data} commands and packs up to MAX_CMDS of them into
// one UDP payload of 8-byte frames: HDR0 HDR1 addr d[31:24] .. d[7:0] TAIL.
// It drives the transmitter's tx_en_pulse / data_length / payload_req_i
// handshake.
// Optional build macro CMD_CHECKSUM_EN: byte 7 becomes TAIL XOR all five
// command bytes instead of the constant TAIL.
module udp_cmd_frame_packer #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned MAX_CMDS = 4,
    parameter logic [7:0]  HDR0     = 8'h55,
    parameter logic [7:0]  HDR1     = 8'hA5,
    parameter logic [7:0]  TAIL     = 8'hF0
) (
    input  logic                         clk125M,
    input  logic                         reset,
    input  logic                         cmd_wr,
    input  logic [7:0]                   cmd_addr,
    input  logic [31:0]                  cmd_data,
    output logic                         cmd_full,
    output logic [$clog2(DEPTH+1)-1:0]   cmd_count,
    output logic                         overflow,
    input  logic                         start,
    output logic                         tx_en_pulse,
    output logic [15:0]                  data_length,
    input  logic                         payload_req_i,
    output logic [7:0]                   payload_dat_o,
    input  logic                         tx_done,
    output logic                         busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned NW = $clog2(MAX_CMDS + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_CMDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_REQ,
        S_SEND,
        S_WAIT_DONE
    } state_t;

    state_t state, state_next;

    logic [39:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic          push, pop, launch, consume;
    logic [39:0]   head;
    logic [7:0]    tail_byte;
    logic [2:0]    byte_idx;
    logic [NW-1:0] frame_cnt, n_frames, n_launch;

    assign head      = mem[rd_ptr];
    assign cmd_count = count;
    assign cmd_full  = (count == DEPTH_C);
    assign overflow  = ovf;
    assign push      = cmd_wr && !cmd_full;
    assign n_launch  = (count >= MAX_C) ? NW'(MAX_CMDS) : NW'(count);

`ifdef CMD_CHECKSUM_EN
    assign tail_byte = TAIL ^ head[39:32] ^ head[31:24] ^ head[23:16]
                     ^ head[15:8] ^ head[7:0];
`else
    assign tail_byte = TAIL;
`endif

    // Command storage write port.
    always_ff @(posedge clk125M) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_addr, cmd_data};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk125M) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
            if (cmd_wr && cmd_full) begin
                ovf <= 1'b1;
            end
        end
    end

    // Packet FSM state register.
    always_ff @(posedge clk125M) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake outputs and byte-consume/pop strobes.
    // The first request cycle arrives in WAIT_REQ and already consumes byte 0,
    // so HDR0 is presented combinationally without a bubble.
    always_comb begin
        state_next  = state;
        launch      = 1'b0;
        consume     = 1'b0;
        pop         = 1'b0;
        tx_en_pulse = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if ((start && count != '0) || count >= MAX_C) begin
                    launch     = 1'b1;
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tx_en_pulse = 1'b1;
                state_next  = S_WAIT_REQ;
            end
            S_WAIT_REQ: begin
                if (payload_req_i) begin
                    consume    = 1'b1;
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (!payload_req_i) begin
                    state_next = S_WAIT_DONE;
                end else begin
                    consume = 1'b1;
                    if (byte_idx == 3'd7 && count != '0) begin
                        pop = 1'b1;
                        if (frame_cnt + 1'b1 == n_frames) begin
                            state_next = S_WAIT_DONE;
                        end
                    end
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Byte index, frame counter and latched packet length.
    always_ff @(posedge clk125M) begin
        if (reset) begin
            byte_idx    <= '0;
            frame_cnt   <= '0;
            n_frames    <= '0;
            data_length <= '0;
        end else if (launch) begin
            byte_idx    <= '0;
            frame_cnt   <= '0;
            n_frames    <= n_launch;
            data_length <= 16'({n_launch, 3'b000});
        end else if (consume) begin
            byte_idx <= byte_idx + 1'b1;
            if (pop) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Payload byte mux from byte index and FIFO head; zero outside the stream.
    always_comb begin
        payload_dat_o = '0;
        if (state == S_WAIT_REQ || state == S_SEND) begin
            case (byte_idx)
                3'd0:    payload_dat_o = HDR0;
                3'd1:    payload_dat_o = HDR1;
                3'd2:    payload_dat_o = head[39:32];
                3'd3:    payload_dat_o = head[31:24];
                3'd4:    payload_dat_o = head[23:16];
                3'd5:    payload_dat_o = head[15:8];
                3'd6:    payload_dat_o = head[7:0];
                default: payload_dat_o = tail_byte;
            endcase
        end
    end

endmodule
